// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-bus sequencer.
//   NREGS_DEF : default number of sequenced registers
//   IW        : register index width for the default register count
//   state_e   : controller FSM state encoding
package reg_ctrl_pkg;

    localparam int unsigned NREGS_DEF = 8;
    localparam int unsigned IW        = $clog2(NREGS_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable.
//   en     : when 0 the output is all zero
//   idx    : binary register index
//   onehot : NREGS-wide one-hot (or zero) select vector
module onehot_dec
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned IDXW  = IW
) (
    input  logic             en,
    input  logic [IDXW-1:0]  idx,
    output logic [NREGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            onehot[i] = en && (idx == IDXW'(i));
        end
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Register-bus operation sequencer: IDLE -> READ -> EXEC -> WRITE.
//   clk, rst                   : clock, asynchronous active-high reset
//   req_valid / req_ready      : request handshake (accepted only in IDLE)
//   req_rs_a, req_rs_b, req_rd : source A/B and destination register indices
//   req_wr                     : write result back to req_rd
//   exec_start / exec_done     : execution unit start pulse / result valid
//   sel_a, sel_b, reg_en       : one-hot per-register bus and write enables
//   done, err                  : completion / timeout-abort pulses
//   op_count                   : wrapping count of completed operations
// Every output is a flop; values are computed from the next state so they
// line up with the state they belong to. WAIT_MAX must be in 1..255.
module reg_bus_ctrl
    import reg_ctrl_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned R0_LOCK  = 1,
    localparam int unsigned IDX_W   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_rs_a,
    input  logic [IDX_W-1:0] req_rs_b,
    input  logic [IDX_W-1:0] req_rd,
    input  logic             req_wr,
    output logic             exec_start,
    input  logic             exec_done,
    output logic [NREGS-1:0] sel_a,
    output logic [NREGS-1:0] sel_b,
    output logic [NREGS-1:0] reg_en,
    output logic             done,
    output logic             err,
    output logic [15:0]      op_count
);

    localparam logic [7:0] WaitLim = 8'(WAIT_MAX);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rs_a_q, rs_a_d, rs_b_q, rs_b_d, rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [7:0]         wait_q, wait_d;
    logic               err_d;

    logic               sel_en, wr_en;
    logic [NREGS-1:0]   sel_a_d, sel_b_d, reg_en_d;
    logic               done_d, exec_start_d;
    logic [15:0]        op_count_d;

    logic               req_ready_q;
    logic               exec_start_q, done_q, err_q;
    logic [NREGS-1:0]   sel_a_q, sel_b_q, reg_en_q;
    logic [15:0]        op_count_q;

    always_comb begin
        state_d = state_q;
        rs_a_d  = rs_a_q;
        rs_b_d  = rs_b_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    rs_a_d  = req_rs_a;
                    rs_b_d  = req_rs_b;
                    rd_d    = req_rd;
                    wr_d    = req_wr;
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StExec;
                wait_d  = 8'd1;
            end
            StExec: begin
                // A result arriving on the last allowed cycle still completes.
                if (exec_done) begin
                    state_d = StWrite;
                    wait_d  = '0;
                end else if (wait_q == WaitLim) begin
                    state_d = StIdle;
                    wait_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign sel_en       = (state_d == StRead) || (state_d == StExec);
    assign wr_en        = (state_d == StWrite) && wr_d && !((R0_LOCK != 0) && (rd_d == '0));
    assign exec_start_d = (state_q == StRead);
    assign done_d       = (state_d == StWrite);
    assign op_count_d   = op_count_q + {15'd0, done_d};

    onehot_dec #(.NREGS(NREGS), .IDXW(IDX_W)) u_dec_a (
        .en     (sel_en),
        .idx    (rs_a_d),
        .onehot (sel_a_d)
    );

    onehot_dec #(.NREGS(NREGS), .IDXW(IDX_W)) u_dec_b (
        .en     (sel_en),
        .idx    (rs_b_d),
        .onehot (sel_b_d)
    );

    onehot_dec #(.NREGS(NREGS), .IDXW(IDX_W)) u_dec_w (
        .en     (wr_en),
        .idx    (rd_d),
        .onehot (reg_en_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rs_a_q       <= '0;
            rs_b_q       <= '0;
            rd_q         <= '0;
            wr_q         <= 1'b0;
            wait_q       <= '0;
            req_ready_q  <= 1'b1;
            exec_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            reg_en_q     <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            rs_a_q       <= rs_a_d;
            rs_b_q       <= rs_b_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            wait_q       <= wait_d;
            req_ready_q  <= (state_d == StIdle);
            exec_start_q <= exec_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            reg_en_q     <= reg_en_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign exec_start = exec_start_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sel_a      = sel_a_q;
    assign sel_b      = sel_b_q;
    assign reg_en     = reg_en_q;
    assign op_count   = op_count_q;

endmodule

// File: doc/reg_bus_ctrl.md
REG_BUS_CTRL -- requirements
Module: reg_bus_ctrl

Interface
REQ-001 Parameter NREGS, 8, number of reg16 registers sequenced; index width IW = clog2(NREGS) = 3.
REQ-002 Parameter WAIT_MAX, 15, maximum EXEC cycles before abort; range 1..255.
REQ-003 Parameter R0_LOCK, 1, when 1 writes to register 0 are suppressed.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  operation request present.
REQ-007 req_ready  output  1  controller accepts a request this cycle.
REQ-008 req_rs_a  input  IW  register index driven onto bus A.
REQ-009 req_rs_b  input  IW  register index driven onto bus B.
REQ-010 req_rd  input  IW  destination register index.
REQ-011 req_wr  input  1  1 = write back result to req_rd.
REQ-012 exec_start  output  1  one-cycle pulse to the execution unit.
REQ-013 exec_done  input  1  execution unit result valid on write bus.
REQ-014 sel_a  output  NREGS  one-hot per-register selA enables.
REQ-015 sel_b  output  NREGS  one-hot per-register selB enables.
REQ-016 reg_en  output  NREGS  one-hot per-register write enables.
REQ-017 done  output  1  one-cycle pulse, operation completed.
REQ-018 err  output  1  one-cycle pulse, operation aborted on timeout.
REQ-019 op_count  output  16  count of operations completed with done.

Function
REQ-020 FSM states SHALL be IDLE, READ, EXEC, WRITE; next state registered.
REQ-021 IDLE: req_ready=1; on req_valid the fields SHALL be captured and the FSM SHALL go to READ; otherwise stay.
REQ-022 req_ready SHALL be 0 in every state other than IDLE; requests are never queued.
REQ-023 READ (exactly 1 cycle): sel_a=onehot(rs_a), sel_b=onehot(rs_b); next state EXEC.
REQ-024 EXEC: sel_a/sel_b held as in READ; exec_start=1 only in the first EXEC cycle; wait counter starts at 1 on entry.
REQ-025 EXEC with exec_done=1: next state WRITE.
REQ-026 EXEC with exec_done=0 and wait counter==WAIT_MAX: err pulses next cycle, no write, next state IDLE, op_count unchanged.
REQ-027 exec_done and timeout in the same cycle: exec_done wins (WRITE, no err).
REQ-028 WRITE (exactly 1 cycle): reg_en=onehot(rd) if req_wr=1 and not (R0_LOCK=1 and rd=0), else all zero; sel_a/sel_b=0; done=1; op_count+1; next state IDLE.
REQ-029 op_count SHALL wrap 16'hFFFF -> 16'h0000 without flag.
REQ-030 rs_a==rs_b, rd==rs_a or rd==rs_b SHALL all be legal with no special handling.
REQ-031 At every cycle popcount(sel_a)<=1, popcount(sel_b)<=1, popcount(reg_en)<=1; reg_en never coincides with nonzero sel_a/sel_b.
REQ-032 All outputs SHALL be registered (Moore); no combinational path from inputs to outputs except none.
REQ-033 exec_done outside EXEC SHALL be ignored.
REQ-034 Latency request accept to done: 3 + (EXEC cycles) clocks; minimum 4 when exec_done arrives in first EXEC cycle.

Reset
REQ-035 On rst: FSM=IDLE, sel_a=sel_b=reg_en=0, exec_start=done=err=0, op_count=0, wait counter=0, captured fields=0.
REQ-036 req_ready SHALL be 1 on the first clock after rst deasserts.
REQ-037 rst asserted mid-operation SHALL drop all enables immediately (asynchronously), and the aborted operation SHALL produce neither done nor err.

Structure
REQ-038 Shared package reg_ctrl_pkg SHALL hold the state enum, NREGS default and IW constant.
REQ-039 One sub-module, onehot_dec (IW -> NREGS binary-to-one-hot decoder with enable), SHALL be instantiated three times.

Verification
REQ-040 Reset then req rs_a=2, rs_b=5, rd=3, wr=1, exec_done 1st EXEC cycle -> sel_a=8'h04, sel_b=8'h20 two cycles, reg_en=8'h08 one cycle, done, op_count=1.
REQ-041 exec_done withheld with WAIT_MAX=15 -> err pulse after 15 EXEC cycles, reg_en stays 0, op_count unchanged, req_ready returns to 1.
REQ-042 rd=0, wr=1, R0_LOCK=1 -> done pulses, reg_en=0; with wr=0 and rd=6 -> reg_en=0, done pulses.
REQ-043 rst asserted in EXEC cycle 3 -> sel_a/sel_b=0 same cycle, no done/err, req_ready=1 after release.
REQ-044 exec_done and timeout coincide at cycle 15 -> WRITE taken, done=1, err=0.
REQ-045 Back-to-back requests held valid; rs_a=rs_b=7 -> sel_a=sel_b=8'h80, one-hot invariants hold throughout; preload op_count to 16'hFFFF via 65535 ops -> next done wraps to 0.
